// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit hex seven-segment driver with shadow capture and blanking.
// Optional macro SEVEN_SEG_LEADING_ZERO_BLANK_EN also darkens leading zero digits.
module seven_segment_scanner #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [4*NUM_DIGITS-1:0]   i_num_binary,
  input  logic [NUM_DIGITS-1:0]     i_blank,
  input  logic                      i_load,
  output logic [6:0]                o_display,
  output logic [NUM_DIGITS-1:0]     o_digit_en,
  output logic                      o_frame_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0]         PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF    = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] EN_OFF     = {NUM_DIGITS{ACTIVE_LOW}};

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [DW-1:0]         r_data;
  logic [NUM_DIGITS-1:0] r_blank;
  logic [6:0]            r_display;
  logic [NUM_DIGITS-1:0] r_digit_en;
  logic                  r_frame_done;

  logic                  w_tick;
  logic [PW-1:0]         w_presc_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic [DW-1:0]         w_data_nxt;
  logic [NUM_DIGITS-1:0] w_blank_nxt;
  logic [3:0]            w_nib;
  logic                  w_dark;
  logic [IW-1:0]         w_msd;
  logic [6:0]            w_display_nxt;
  logic [NUM_DIGITS-1:0] w_digit_en_nxt;
  logic                  w_frame_done_nxt;

  // Segments-on pattern (g..a) for one hex nibble, before polarity
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'b0000000;
    case (nib)
      4'h0: seg = 7'b0111111;
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      4'hF: seg = 7'b1110001;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  // Register bank: scan counters, shadow copy and registered pin drivers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_data       <= '0;
      r_blank      <= '0;
      r_display    <= SEG_OFF;
      r_digit_en   <= EN_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_presc_nxt;
      r_idx        <= w_idx_nxt;
      r_data       <= w_data_nxt;
      r_blank      <= w_blank_nxt;
      r_display    <= w_display_nxt;
      r_digit_en   <= w_digit_en_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Next-state and output decode; outputs follow the pre-edge index and shadow
  always_comb begin
    w_tick           = (r_presc == PRESC_LAST);
    w_presc_nxt      = r_presc + PW'(1);
    w_idx_nxt        = r_idx;
    w_data_nxt       = r_data;
    w_blank_nxt      = r_blank;
    w_nib            = 4'h0;
    w_dark           = 1'b0;
    w_msd            = '0;
    w_digit_en_nxt   = '0;
    w_frame_done_nxt = w_tick && (r_idx == IDX_LAST);

    if (w_tick) begin
      w_presc_nxt = '0;
      w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end

    if (i_load) begin
      w_data_nxt  = i_num_binary;
      w_blank_nxt = i_blank;
    end

    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (IW'(k) == r_idx) begin
        w_nib             = r_data[4*k +: 4];
        w_dark            = r_blank[k];
        w_digit_en_nxt[k] = 1'b1;
      end
      if (r_data[4*k +: 4] != 4'h0) begin
        w_msd = IW'(k);
      end
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (r_idx > w_msd) begin
      w_dark = 1'b1;
    end
`endif

    w_display_nxt  = w_dark ? SEG_OFF
                            : (ACTIVE_LOW ? ~hex_to_seg(w_nib) : hex_to_seg(w_nib));
    w_digit_en_nxt = w_digit_en_nxt ^ EN_OFF;
  end

  assign o_display    = r_display;
  assign o_digit_en   = r_digit_en;
  assign o_frame_done = r_frame_done;

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Parametrised, time-multiplexed driver for an N-digit hexadecimal seven-segment display. It captures a packed hex word and per-digit blank mask on LOAD, then scans the digits one at a time at a programmable rate. Each digit is decoded to segments on a single shared bus, with a matching digit-enable one-hot. It sits between datapath blocks and the board display pins and replaces per-digit static decoders.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; legal range 1..8.
SCAN_DIV, 50000, clock cycles each digit is held; legal range ≥1.
ACTIVE_LOW, 1, output polarity. 1 means segments and digit enables are asserted low. 0 means asserted high.

Ports:
CLK  input  1  system clock, rising-edge.
RESET_N  input  1  asynchronous, active-low reset.
NUM_BINARY  input  4*NUM_DIGITS  packed hex digits; digit k = NUM_BINARY[4k+3:4k], digit 0 rightmost.
BLANK  input  NUM_DIGITS  per-digit blank request, 1 = digit dark.
LOAD  input  1  capture NUM_BINARY and BLANK into shadow registers.
DISPLAY  output  7  segments, bit6=g … bit0=a, polarity per ACTIVE_LOW.
DIGIT_EN  output  NUM_DIGITS  one-hot digit select, polarity per ACTIVE_LOW.
FRAME_DONE  output  1  one-cycle pulse when scan wraps from the last digit to digit 0.

Behaviour:
- Reset (RESET_N low, acts immediately, no clock needed):
  - prescaler=0, digit index=0, shadow data=0, shadow blank=0.
  - DISPLAY all segments off: 7'h7F if ACTIVE_LOW=1, 7'h00 if ACTIVE_LOW=0.
  - DIGIT_EN all off, FRAME_DONE=0.
  - Reset mid-scan abandons the scan. First edge after release drives digit 0.
- Prescaler:
  - counts 0..SCAN_DIV-1. The tick is the cycle at SCAN_DIV-1; the counter then returns to 0.
  - SCAN_DIV=1 gives a tick every cycle.
- Digit index:
  - advances on tick; wraps NUM_DIGITS-1 → 0.
  - FRAME_DONE is registered high for exactly the cycle following the wrapping edge.
  - NUM_DIGITS=1: index fixed at 0, FRAME_DONE pulses every tick.
- Shadow registers:
  - LOAD high at an edge captures NUM_BINARY and BLANK.
  - Captured values drive the outputs from the next edge (1-cycle latency).
  - Scan position and prescaler are unaffected by LOAD.
  - LOAD held high re-captures every cycle.
- Outputs are registers, recomputed every edge from the current index and shadow state:
  - DIGIT_EN asserts only bit [index].
  - DISPLAY is the hex decode of shadow digit [index]. Segments-on patterns (g..a), before polarity:
    - 0:0111111, 1:0000110, 2:1011011, 3:1001111
    - 4:1100110, 5:1101101, 6:1111101, 7:0000111
    - 8:1111111, 9:1101111, A:1110111, b:1111100
    - C:0111001, d:1011110, E:1111001, F:1110001
  - ACTIVE_LOW=1 inverts the patterns above.
- Blanking: if shadow blank[index]=1, DISPLAY is all-off while DIGIT_EN still selects that digit (timing uniform).
- Simultaneous LOAD and tick: the new index shows the new data one edge later. No stale-mix within a digit beyond one cycle.
- No combinational path from any input to any output.

Optional Feature:
SEVEN_SEG_LEADING_ZERO_BLANK_EN:
- Defined: digits above the most significant non-zero shadow digit are additionally blanked.
  - Digit 0 is never auto-blanked, so value 0 shows "0".
  - The result is OR'd with BLANK.
- Undefined: only BLANK suppresses digits.

Test Plan:
- NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1. Hold RESET_N low → DISPLAY=7'h7F, DIGIT_EN=4'hF, FRAME_DONE=0. Assert RESET_N low mid-scan → same values before the next edge.
- LOAD 16'h1234, BLANK=0:
  - digit 0: DISPLAY=7'b0011001, DIGIT_EN=4'b1110.
  - 4 cycles later, digit 1: DISPLAY=7'b0110000, DIGIT_EN=4'b1101.
  - FRAME_DONE pulses once every 16 cycles.
- LOAD 16'hF0A0 → digit 3 slot DISPLAY=7'b0001110; digit 2 slot 7'b1000000; digit 1 slot 7'b0001000.
- LOAD 16'h1234 with BLANK=4'b0010 → during DIGIT_EN=4'b1101, DISPLAY=7'h7F; other digits unaffected.
- LOAD 16'h5555 while digit 2 is active, mid-hold:
  - DISPLAY=7'b0010010 one edge later.
  - DIGIT_EN and the prescaler phase are unchanged.
  - SCAN_DIV=1 run: index advances every cycle.
- With SEVEN_SEG_LEADING_ZERO_BLANK_EN, LOAD 16'h0005:
  - digits 3..1 DISPLAY=7'h7F; digit 0 DISPLAY=7'b0010010.
  - LOAD 16'h0000 → digit 0 DISPLAY=7'b1000000.
  - Without the macro, 16'h0005 shows 7'b1000000 on digits 3..1.
